// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with an integrated busy scoreboard.
// Ports: clk/rst; NUM_RD combinational read ports (rd_addr -> rd_data, rd_busy);
//        write ports wr0 (WB) and wr1 (late/MEM, wins on equal address);
//        reserve port rsv_en/rsv_addr; registered busy_vec and wr_collide pulse.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [(1<<ADDR_W)-1:0]     busy_vec,
    output logic                       wr_collide
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              collide;

    // Qualified write/reserve strobes. With a hard-wired zero register any
    // access to address 0 is discarded here, so it can neither update the
    // array, touch the scoreboard, forward data nor raise a collision.
    logic wr0_ok;
    logic wr1_ok;
    logic rsv_ok;
    logic wr0_drop;

    always_comb begin
        wr0_ok = wr0_en;
        wr1_ok = wr1_en;
        rsv_ok = rsv_en;
        if (ZERO_REG != 0) begin
            if (wr0_addr == '0) wr0_ok = 1'b0;
            if (wr1_addr == '0) wr1_ok = 1'b0;
            if (rsv_addr == '0) rsv_ok = 1'b0;
        end
        // The late port carries the younger result, so it wins a tie.
        wr0_drop = wr0_ok && wr1_ok && (wr0_addr == wr1_addr);
    end

    // Register array: one-cycle write latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (wr0_ok && !wr0_drop) begin
                mem[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                mem[wr1_addr] <= wr1_data;
            end
        end
    end

    // Scoreboard next state. The reserve is applied last so that a newly
    // issued producer keeps its destination busy even if an older producer
    // retires to the same register on this edge.
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok) busy_nxt[wr0_addr] = 1'b0;
        if (wr1_ok) busy_nxt[wr1_addr] = 1'b0;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            collide <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            collide <= wr0_drop;
        end
    end

    assign busy_vec   = busy;
    assign wr_collide = collide;

    // Read ports. Forwarding mirrors the write priority (wr1 over wr0), and a
    // forwarded operand is no longer a hazard. A same-cycle reserve is not
    // visible here: the reserving instruction is younger than the reader.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] data;
        logic              hazard;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            hit0   = (BYPASS != 0) && wr0_ok && (wr0_addr == ra);
            hit1   = (BYPASS != 0) && wr1_ok && (wr1_addr == ra);
            data   = mem[ra];
            hazard = busy[ra];
            if (hit1) begin
                data = wr1_data;
            end else if (hit0) begin
                data = wr0_data;
            end
            if (hit0 || hit1) begin
                hazard = 1'b0;
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                data   = '0;
                hazard = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_busy[i]                  = hazard;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file with an integrated busy scoreboard; the next-generation register file for the core datapath.
- Provides NUM_RD combinational read ports and two synchronous write ports (WB and late/MEM), with optional write-to-read bypass and optional hard-wired zero register.
- Tracks per-register pending-write (busy) state so the issue stage detects RAW hazards without an external scoreboard.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the pre-edge value.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  per-port hazard flag, combinational.
- wr0_en  in  1  write port 0 enable (WB).
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (late/MEM).
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- rsv_en  in  1  reserve: mark rsv_addr busy (instruction issued with a destination).
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  DEPTH  registered busy bits, bit k = register k.
- wr_collide  out  1  registered pulse: both write ports hit the same address on the previous edge.

Behaviour:
- Reset (async, rst=1): all registers = 0, busy_vec = 0, wr_collide = 0. rd_data reflects the zeroed array while rst is held. Reset mid-operation discards all in-flight writes and reservations; the clk edge coincident with rst has no effect.
- Writes: on posedge clk; the array updates at the edge (1-cycle write latency).
  - Both ports enabled with equal addresses: wr1 wins, wr0 is dropped, wr_collide = 1 for exactly the following cycle; otherwise wr_collide = 0.
  - Distinct addresses: both write.
- Reads: combinational, rd_data[i] = reg[rd_addr[i]].
  - BYPASS=1: if wr1_en and wr1_addr == rd_addr[i], return wr1_data; else if wr0_en and wr0_addr == rd_addr[i], return wr0_data; else the array value. Priority matches the write rule.
  - BYPASS=0: always the array value.
- ZERO_REG=1: address 0 reads 0 on every port (including when bypassed), writes to 0 are ignored and do not trigger wr_collide, reserves to 0 are ignored, busy_vec[0] is held at 0.
- Scoreboard (per register k, at posedge clk):
  - Set busy[k] if rsv_en and rsv_addr == k.
  - Clear busy[k] if a write (either port) targets k.
  - Set and clear in the same cycle: set wins (a newer producer has issued).
  - Reserving an already-busy register leaves it busy; there is no counting.
- rd_busy[i] = busy[rd_addr[i]], except with BYPASS=1 it is forced to 0 when a write to rd_addr[i] occurs that same cycle (the data is forwarded).
  - rd_busy ignores a same-cycle rsv_en; the reserving instruction is younger than the reader.
- No internal FSM beyond the array, busy bits and the collide flag. All outputs are fully defined for any input combination.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst asynchronously mid-cycle -> rd_data for r5 = 0 immediately; busy_vec = 0; wr_collide = 0.
- Basic write/read: wr0 r3 = 0x12345678, next cycle read r3 on all ports -> 0x12345678 on every port; BYPASS=1 returns it in the write cycle, BYPASS=0 returns 0 in the write cycle.
- Collision: wr0 r7 = 0x1111, wr1 r7 = 0x2222 same edge -> r7 = 0x2222; wr_collide = 1 for one cycle, then 0; BYPASS=1 read in that cycle = 0x2222.
- Scoreboard: rsv r9 -> busy_vec[9] = 1, rd_busy = 1 on a port reading r9; wr1 r9 = 0xA5A5 -> rd_busy = 0 in the write cycle (BYPASS=1), busy_vec[9] = 0 after the edge. Same-edge rsv r9 + wr0 r9 -> busy_vec[9] stays 1.
- Zero register (ZERO_REG=1): wr0 r0 = 0xFFFFFFFF, rsv r0 -> r0 reads 0, busy_vec[0] = 0; wr0 r0 + wr1 r0 together -> wr_collide = 0.
- Parameter sweep: DATA_W=16, ADDR_W=5, NUM_RD=3 -> write distinct values to all 32 registers, read back on all 3 ports in a random order, with no mismatches.
